// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade player-input conditioner: PS/2 scan codes,
// joystick bit positions, key-state record and coin sequencer states.
package arcade_input_pkg;

    // Scan codes matched regardless of the extended flag
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_FIRE1  = 8'h14;
    localparam logic [7:0] SC_FIRE2  = 8'h11;
    // Scan codes that only match with the extended flag clear
    localparam logic [7:0] SC_FIRE3  = 8'h29;
    localparam logic [7:0] SC_START1 = 8'h05;
    localparam logic [7:0] SC_START2 = 8'h06;

    localparam int unsigned JOY_RIGHT  = 0;
    localparam int unsigned JOY_LEFT   = 1;
    localparam int unsigned JOY_DOWN   = 2;
    localparam int unsigned JOY_UP     = 3;
    localparam int unsigned JOY_FIRE1  = 4;
    localparam int unsigned JOY_FIRE2  = 5;
    localparam int unsigned JOY_FIRE3  = 6;
    localparam int unsigned JOY_START1 = 7;
    localparam int unsigned JOY_START2 = 8;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic fire1;
        logic fire2;
        logic fire3;
        logic start1;
        logic start2;
    } keys_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COIN,
        ST_GAP,
        ST_ARMED
    } coin_state_t;

endpackage

// File: rtl/arcade_coin_seq.sv
// Start-to-coin sequencer: a start press yields a COIN_PULSE-cycle coin, a
// START_DELAY-cycle masked gap, then the start requests pass through.
module arcade_coin_seq
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE  = 1_200_000,
    parameter int unsigned START_DELAY = 2_400_000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic start1_req_i,
    input  logic start2_req_i,
    output logic coin_o,
    output logic one_player_o,
    output logic two_players_o
);

    localparam int unsigned CNT_MAX = (COIN_PULSE > START_DELAY) ? COIN_PULSE : START_DELAY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] COIN_LOAD  = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(START_DELAY - 1);

    coin_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_prev_q;
    logic             coin_q, coin_d;
    logic             one_q, one_d;
    logic             two_q, two_d;
    logic             start_any;
    logic             start_rise;

    assign start_any  = start1_req_i | start2_req_i;
    assign start_rise = start_any & ~start_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        coin_d  = 1'b0;
        one_d   = 1'b0;
        two_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    cnt_d   = COIN_LOAD;
                    state_d = ST_COIN;
                end
            end
            ST_COIN: begin
                coin_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = DELAY_LOAD;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_ARMED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ARMED: begin
                one_d = start1_req_i;
                two_d = start2_req_i;
                if (!start_any) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Previous start resets high so a start held through reset is not a press
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            start_prev_q <= 1'b1;
            coin_q       <= 1'b0;
            one_q        <= 1'b0;
            two_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_prev_q <= start_any;
            coin_q       <= coin_d;
            one_q        <= one_d;
            two_q        <= two_d;
        end
    end

    assign coin_o        = coin_q;
    assign one_player_o  = one_q;
    assign two_players_o = two_q;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Player-input conditioner: PS/2 key decode merged with two joysticks into
// registered game buttons plus coin/start sequencing. Optional INPUT_SOCD_EN.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE  = 1_200_000,
    parameter int unsigned START_DELAY = 2_400_000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    output logic        btn_right,
    output logic        btn_left,
    output logic        btn_down,
    output logic        btn_up,
    output logic        btn_fire1,
    output logic        btn_fire2,
    output logic        btn_fire3,
    output logic        btn_coin,
    output logic        btn_one_player,
    output logic        btn_two_players
);

    logic       old_toggle_q;
    keys_t      keys_q, keys_d;
    logic       pressed;
    logic       ext;
    logic [7:0] code;

    assign pressed = ps2_key[9];
    assign ext     = ps2_key[8];
    assign code    = ps2_key[7:0];

    always_comb begin
        keys_d = keys_q;
        if (ps2_key[10] != old_toggle_q) begin
            case (code)
                SC_UP:     keys_d.up    = pressed;
                SC_DOWN:   keys_d.down  = pressed;
                SC_LEFT:   keys_d.left  = pressed;
                SC_RIGHT:  keys_d.right = pressed;
                SC_FIRE1:  keys_d.fire1 = pressed;
                SC_FIRE2:  keys_d.fire2 = pressed;
                SC_FIRE3:  if (!ext) keys_d.fire3  = pressed;
                SC_START1: if (!ext) keys_d.start1 = pressed;
                SC_START2: if (!ext) keys_d.start2 = pressed;
                default: ;
            endcase
        end
    end

    logic req_up, req_down, req_left, req_right;
    logic req_fire1, req_fire2, req_fire3, req_start1, req_start2;

    assign req_up     = keys_q.up     | joystick_0[JOY_UP]     | joystick_1[JOY_UP];
    assign req_down   = keys_q.down   | joystick_0[JOY_DOWN]   | joystick_1[JOY_DOWN];
    assign req_left   = keys_q.left   | joystick_0[JOY_LEFT]   | joystick_1[JOY_LEFT];
    assign req_right  = keys_q.right  | joystick_0[JOY_RIGHT]  | joystick_1[JOY_RIGHT];
    assign req_fire1  = keys_q.fire1  | joystick_0[JOY_FIRE1]  | joystick_1[JOY_FIRE1];
    assign req_fire2  = keys_q.fire2  | joystick_0[JOY_FIRE2]  | joystick_1[JOY_FIRE2];
    assign req_fire3  = keys_q.fire3  | joystick_0[JOY_FIRE3]  | joystick_1[JOY_FIRE3];
    assign req_start1 = keys_q.start1 | joystick_0[JOY_START1] | joystick_1[JOY_START1];
    assign req_start2 = keys_q.start2 | joystick_0[JOY_START2] | joystick_1[JOY_START2];

    logic unused_joy;
    assign unused_joy = ^{joystick_0[15:9], joystick_1[15:9]};

    logic dir_up_d, dir_down_d, dir_left_d, dir_right_d;

`ifdef INPUT_SOCD_EN
    // Opposing directions cancel to neutral
    assign dir_up_d    = req_up    & ~req_down;
    assign dir_down_d  = req_down  & ~req_up;
    assign dir_left_d  = req_left  & ~req_right;
    assign dir_right_d = req_right & ~req_left;
`else
    assign dir_up_d    = req_up;
    assign dir_down_d  = req_down;
    assign dir_left_d  = req_left;
    assign dir_right_d = req_right;
`endif

    logic up_q, down_q, left_q, right_q, fire1_q, fire2_q, fire3_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            old_toggle_q <= 1'b0;
            keys_q       <= '0;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            fire1_q      <= 1'b0;
            fire2_q      <= 1'b0;
            fire3_q      <= 1'b0;
        end else begin
            old_toggle_q <= ps2_key[10];
            keys_q       <= keys_d;
            up_q         <= dir_up_d;
            down_q       <= dir_down_d;
            left_q       <= dir_left_d;
            right_q      <= dir_right_d;
            fire1_q      <= req_fire1;
            fire2_q      <= req_fire2;
            fire3_q      <= req_fire3;
        end
    end

    arcade_coin_seq #(
        .COIN_PULSE  (COIN_PULSE),
        .START_DELAY (START_DELAY)
    ) u_coin_seq (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .start1_req_i  (req_start1),
        .start2_req_i  (req_start2),
        .coin_o        (btn_coin),
        .one_player_o  (btn_one_player),
        .two_players_o (btn_two_players)
    );

    assign btn_up    = up_q;
    assign btn_down  = down_q;
    assign btn_left  = left_q;
    assign btn_right = right_q;
    assign btn_fire1 = fire1_q;
    assign btn_fire2 = fire2_q;
    assign btn_fire3 = fire3_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl with COIN_PULSE=4, START_DELAY=3.
module tb_arcade_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic btn_right, btn_left, btn_down, btn_up;
    logic btn_fire1, btn_fire2, btn_fire3;
    logic btn_coin, btn_one_player, btn_two_players;

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl #(
        .COIN_PULSE  (4),
        .START_DELAY (3)
    ) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .ps2_key         (ps2_key),
        .joystick_0      (joystick_0),
        .joystick_1      (joystick_1),
        .btn_right       (btn_right),
        .btn_left        (btn_left),
        .btn_down        (btn_down),
        .btn_up          (btn_up),
        .btn_fire1       (btn_fire1),
        .btn_fire2       (btn_fire2),
        .btn_fire3       (btn_fire3),
        .btn_coin        (btn_coin),
        .btn_one_player  (btn_one_player),
        .btn_two_players (btn_two_players)
    );

    // {right,left,down,up,fire1,fire2,fire3,coin,one,two}
    logic [9:0] outs;
    assign outs = {btn_right, btn_left, btn_down, btn_up, btn_fire1, btn_fire2,
                   btn_fire3, btn_coin, btn_one_player, btn_two_players};

    localparam logic [9:0] O_NONE = 10'h000;
    localparam logic [9:0] O_RL   = 10'h300;
    localparam logic [9:0] O_UD   = 10'h0C0;
    localparam logic [9:0] O_UP   = 10'h040;
    localparam logic [9:0] O_F2   = 10'h010;
    localparam logic [9:0] O_F3   = 10'h008;
    localparam logic [9:0] O_COIN = 10'h004;
    localparam logic [9:0] O_ONE  = 10'h002;
    localparam logic [9:0] O_TWO  = 10'h001;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic tog    = 1'b0;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ps2_evt(input logic pr, input logic [8:0] code);
        tog     = ~tog;
        ps2_key = {tog, pr, code};
    endtask

    initial begin
        reset      = 1'b1;
        ps2_key    = '0;
        joystick_0 = '0;
        joystick_1 = '0;
        tick();
        tick();
        check("reset_outs", outs, O_NONE);
        reset = 1'b0;
        tick();
        check("idle_outs", outs, O_NONE);

        // Extended up key: two-cycle latency
        ps2_evt(1'b1, 9'h175);
        tick();
        check("ps2_up_lat1", outs, O_NONE);
        tick();
        check("ps2_up_press", outs, O_UP);
        ps2_evt(1'b0, 9'h175);
        tick();
        tick();
        check("ps2_up_release", outs, O_NONE);

        // Extended space must not fire
        ps2_evt(1'b1, 9'h129);
        tick();
        tick();
        check("ps2_ext_space", outs, O_NONE);
        ps2_evt(1'b1, 9'h029);
        tick();
        tick();
        check("ps2_space", outs, O_F3);
        ps2_evt(1'b0, 9'h029);
        tick();
        tick();
        check("ps2_space_rel", outs, O_NONE);
        ps2_evt(1'b1, 9'h01C);
        tick();
        tick();
        check("ps2_unmatched", outs, O_NONE);

        // Joystick one-cycle latency, both pads
        joystick_0 = 16'h0008;
        tick();
        check("joy0_up", outs, O_UP);
        joystick_0 = 16'h0000;
        joystick_1 = 16'h0020;
        tick();
        check("joy1_fire2", outs, O_F2);
        joystick_1 = 16'h0000;
        tick();
        check("joy_clear", outs, O_NONE);

        // Coin sequence from player-2 pad start1
        joystick_1 = 16'h0080;
        tick();
        check("coin_lat", outs, O_NONE);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("coin_pulse%0d", i), outs, O_COIN);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("gap%0d", i), outs, O_NONE);
        end
        tick();
        check("armed_one", outs, O_ONE);
        tick();
        check("armed_hold", outs, O_ONE);
        joystick_1 = 16'h0000;
        tick();
        check("armed_release", outs, O_NONE);

        // Simultaneous starts: one coin, then both starts
        joystick_0 = 16'h0180;
        tick();
        check("dual_lat", outs, O_NONE);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("dual_coin%0d", i), outs, O_COIN);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("dual_gap%0d", i), outs, O_NONE);
        end
        tick();
        check("dual_armed", outs, O_ONE | O_TWO);
        joystick_0 = 16'h0000;
        tick();
        check("dual_release", outs, O_NONE);

        // Reset during COIN with start held
        joystick_0 = 16'h0080;
        tick();
        tick();
        check("rst_coin_on", outs, O_COIN);
        reset = 1'b1;
        tick();
        check("rst_mid_coin", outs, O_NONE);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("rst_held%0d", i), outs, O_NONE);
        end
        joystick_0 = 16'h0000;
        tick();
        joystick_0 = 16'h0080;
        tick();
        check("repress_lat", outs, O_NONE);
        tick();
        check("repress_coin", outs, O_COIN);

        // Release during COIN: sequence completes, ARMED passes nothing
        joystick_0 = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rel_coin%0d", i), outs, O_COIN);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rel_tail%0d", i), outs, O_NONE);
        end

        // Opposing directions
        joystick_0 = 16'h0003;
        tick();
`ifdef INPUT_SOCD_EN
        check("socd_lr", outs, O_NONE);
`else
        check("socd_lr", outs, O_RL);
`endif
        joystick_0 = 16'h0004;
        joystick_1 = 16'h0008;
        tick();
`ifdef INPUT_SOCD_EN
        check("socd_ud", outs, O_NONE);
`else
        check("socd_ud", outs, O_UD);
`endif
        joystick_0 = 16'h0000;
        joystick_1 = 16'h0000;
        tick();
        check("final_clear", outs, O_NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
